// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the ALU operand path: opcode values, instruction field
// positions and the issue sequencer state encoding.
package cpu_pkg;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_NOT = 3'd5;
   localparam logic [2:0] ALU_SHL = 3'd6;
   localparam logic [2:0] ALU_SHR = 3'd7;

   localparam int SEL_HI = 18;
   localparam int SEL_LO = 16;
   localparam int A_HI   = 15;
   localparam int A_LO   = 8;
   localparam int B_HI   = 7;
   localparam int B_LO   = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      ISSUE = 3'd3,
      DONE  = 3'd4
   } seq_state_e;

endpackage

// File: rtl/alu_issue_sequencer.sv
`timescale 1ns/1ps
// Walks a program in instruction memory and issues each split word to the ALU operand
// stage over valid/ready. Optional fetch parity check: define ALU_ISSUE_PARITY_EN.
module alu_issue_sequencer
   import cpu_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 19
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [PC_W-1:0]    prog_len,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_rvalid,
`ifdef ALU_ISSUE_PARITY_EN
   input  logic               mem_rpar,
   output logic               par_err,
`endif
   output logic               iss_valid,
   input  logic               iss_ready,
   output logic [2:0]         alu_sel,
   output logic [7:0]         a,
   output logic [7:0]         b,
   output logic               busy,
   output logic               done
);

   seq_state_e state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] len_q, len_d;
   logic [PC_W-1:0] pc_inc;
   logic [2:0] sel_q, sel_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic word_ok;

   assign pc_inc = pc_q + 1'b1;

`ifdef ALU_ISSUE_PARITY_EN
   logic par_err_q, par_err_d;
   assign word_ok = (mem_rpar == ^mem_rdata);
`else
   assign word_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A run ends after the transfer of the last word; a corrupt fetch aborts straight to DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (prog_len != '0) ? FETCH : DONE;
         FETCH:   state_d = WAIT;
         WAIT:    if (mem_rvalid) state_d = word_ok ? ISSUE : DONE;
         ISSUE:   if (iss_ready) state_d = (pc_inc == len_q) ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_d  = pc_q;
      len_d = len_q;
      sel_d = sel_q;
      a_d   = a_q;
      b_d   = b_q;
      if (state_q == IDLE && start) begin
         len_d = prog_len;
         pc_d  = '0;
      end
      if (state_q == WAIT && mem_rvalid && word_ok) begin
         sel_d = mem_rdata[SEL_HI:SEL_LO];
         a_d   = mem_rdata[A_HI:A_LO];
         b_d   = mem_rdata[B_HI:B_LO];
      end
      if (state_q == ISSUE && iss_ready) begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= '0;
         len_q <= '0;
         sel_q <= ALU_ADD;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         pc_q  <= pc_d;
         len_q <= len_d;
         sel_q <= sel_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

`ifdef ALU_ISSUE_PARITY_EN
   // Sticky error flag, only cleared by the next accepted start.
   always_comb begin
      par_err_d = par_err_q;
      if (state_q == IDLE && start) begin
         par_err_d = 1'b0;
      end else if (state_q == WAIT && mem_rvalid && !word_ok) begin
         par_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign par_err = par_err_q;
`endif

   always_comb begin
      mem_req   = (state_q == FETCH);
      mem_addr  = pc_q;
      iss_valid = (state_q == ISSUE);
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      alu_sel   = sel_q;
      a         = a_q;
      b         = b_q;
   end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for alu_issue_sequencer: table-driven basic run, hand-written corner
// sequences and randomized programs compared against a queue-based program model.
module tb_alu_issue_sequencer;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 19;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [PC_W-1:0] prog_len;
   logic mem_req;
   logic [PC_W-1:0] mem_addr;
   logic [INSTR_W-1:0] mem_rdata;
   logic mem_rvalid;
   logic iss_valid;
   logic iss_ready;
   logic [2:0] alu_sel;
   logic [7:0] a;
   logic [7:0] b;
   logic busy;
   logic done;
`ifdef ALU_ISSUE_PARITY_EN
   logic mem_rpar;
   logic par_err;
`endif

   alu_issue_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .prog_len   (prog_len),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
`ifdef ALU_ISSUE_PARITY_EN
      .mem_rpar   (mem_rpar),
      .par_err    (par_err),
`endif
      .iss_valid  (iss_valid),
      .iss_ready  (iss_ready),
      .alu_sel    (alu_sel),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [INSTR_W-1:0] word;
      logic [2:0] sel;
      logic [7:0] opA;
      logic [7:0] opB;
   } vec_t;

   typedef struct {
      logic [2:0] sel;
      logic [7:0] opA;
      logic [7:0] opB;
   } iss_t;

   logic [INSTR_W-1:0] progMem [256];
   int reqQ [$];
   iss_t obsQ [$];
   int doneCount;
   bit validSeen;
   int memLat;
   bit randLat;
   bit randReady;
   bit strayRvalid;
   int stallIdx;
   int stallLeft;
   int corruptAddr;
   int checks;
   int failures;
   vec_t basicVec [3];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int len);
      @(negedge clk);
      prog_len = PC_W'(len);
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic clearRun();
      reqQ.delete();
      obsQ.delete();
      doneCount = 0;
      validSeen = 1'b0;
   endtask

   task automatic finishRun(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < budget);
      checkOutput("doneSeen", done, 1);
      @(negedge clk);
      checkOutput("doneFalls", done, 0);
      checkOutput("busyFalls", busy, 0);
      checkOutput("doneCount", doneCount, 1);
   endtask

   // Reference: a run of len words fetches addresses 0..len-1 in order and issues each field split.
   task automatic checkRun(input int len);
      int w;
      checkOutput("reqCount", reqQ.size(), len);
      checkOutput("issCount", obsQ.size(), len);
      for (int i = 0; i < len; i++) begin
         if (i < reqQ.size()) checkOutput("reqAddr", reqQ[i], i);
         if (i < obsQ.size()) begin
            w = int'(progMem[i]);
            checkOutput("issSel", obsQ[i].sel, w / 65536);
            checkOutput("issA", obsQ[i].opA, (w / 256) % 256);
            checkOutput("issB", obsQ[i].opB, w % 256);
         end
      end
   endtask

   task automatic fillRandom(input int len);
      for (int i = 0; i < len; i++) progMem[i] = INSTR_W'($urandom);
   endtask

   // Environment: memory responder, downstream ready driver and handshake monitor.
   initial begin
      int waitCnt;
      int pendAddr;
      bit prevStall;
      iss_t prevIss;
      waitCnt    = 0;
      pendAddr   = -1;
      prevStall  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      iss_ready  = 1'b0;
`ifdef ALU_ISSUE_PARITY_EN
      mem_rpar   = 1'b0;
`endif
      forever begin
         @(negedge clk);
         if (rst) begin
            waitCnt    = 0;
            mem_rvalid = 1'b0;
            iss_ready  = 1'b0;
            prevStall  = 1'b0;
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = INSTR_W'($urandom);
            if (mem_req) begin
               reqQ.push_back(int'(mem_addr));
               pendAddr = int'(mem_addr);
               waitCnt  = randLat ? int'($urandom_range(1, 4)) : memLat;
            end else if (waitCnt > 0) begin
               checkOutput("addrHeld", mem_addr, pendAddr);
               waitCnt--;
               if (waitCnt == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = progMem[pendAddr];
               end
            end else if (strayRvalid) begin
               mem_rvalid = 1'b1;
            end
`ifdef ALU_ISSUE_PARITY_EN
            mem_rpar = (^mem_rdata) ^ (mem_rvalid && pendAddr == corruptAddr);
`endif
            if (iss_valid && obsQ.size() == stallIdx && stallLeft > 0) begin
               iss_ready = 1'b0;
               stallLeft--;
            end else begin
               iss_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (prevStall) begin
               checkOutput("stallValid", iss_valid, 1);
               checkOutput("stallSel", alu_sel, prevIss.sel);
               checkOutput("stallA", a, prevIss.opA);
               checkOutput("stallB", b, prevIss.opB);
               checkOutput("stallNoReq", mem_req, 0);
            end
            prevStall = iss_valid && !iss_ready;
            prevIss   = '{alu_sel, a, b};
            if (iss_valid) validSeen = 1'b1;
            if (iss_valid && iss_ready) obsQ.push_back('{alu_sel, a, b});
            if (done) doneCount++;
         end
      end
   end

   initial begin
      int len;
      int n;
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      start       = 1'b0;
      prog_len    = '0;
      memLat      = 1;
      randLat     = 1'b0;
      randReady   = 1'b0;
      strayRvalid = 1'b0;
      stallIdx    = -1;
      stallLeft   = 0;
      corruptAddr = -1;
      clearRun();
      basicVec[0] = '{19'h10503, 3'd1, 8'h05, 8'h03};
      basicVec[1] = '{19'h20FF0, 3'd2, 8'h0F, 8'hF0};
      basicVec[2] = '{19'h4AA55, 3'd4, 8'hAA, 8'h55};

      #12;
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstMemReq", mem_req, 0);
      checkOutput("rstMemAddr", mem_addr, 0);
      checkOutput("rstIssValid", iss_valid, 0);
      checkOutput("rstSel", alu_sel, 0);
      checkOutput("rstA", a, 0);
      checkOutput("rstB", b, 0);
`ifdef ALU_ISSUE_PARITY_EN
      checkOutput("rstParErr", par_err, 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] basic table-driven run");
      for (int i = 0; i < 3; i++) progMem[i] = basicVec[i].word;
      clearRun();
      applyStimulus(3);
      finishRun(100);
      checkOutput("basicIssCount", obsQ.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < reqQ.size()) checkOutput("basicAddr", reqQ[i], i);
         if (i < obsQ.size()) begin
            checkOutput("basicSel", obsQ[i].sel, basicVec[i].sel);
            checkOutput("basicA", obsQ[i].opA, basicVec[i].opA);
            checkOutput("basicB", obsQ[i].opB, basicVec[i].opB);
         end
      end

      $display("[TB] backpressure on second instruction");
      fillRandom(3);
      stallIdx  = 1;
      stallLeft = 5;
      clearRun();
      applyStimulus(3);
      finishRun(100);
      checkRun(3);
      checkOutput("stallConsumed", stallLeft, 0);
      stallIdx = -1;

      $display("[TB] zero length");
      clearRun();
      applyStimulus(0);
      @(negedge clk);
      checkOutput("zeroDone", done, 1);
      checkOutput("zeroBusy", busy, 1);
      @(negedge clk);
      checkOutput("zeroDoneFalls", done, 0);
      checkOutput("zeroIdle", busy, 0);
      checkOutput("zeroNoReq", reqQ.size(), 0);
      checkOutput("zeroNoValid", validSeen, 0);
      checkOutput("zeroDoneCount", doneCount, 1);

      $display("[TB] long latency, stray rvalid, mid-run start");
      memLat      = 4;
      strayRvalid = 1'b1;
      clearRun();
      repeat (3) @(negedge clk);
      strayRvalid = 1'b0;
      @(negedge clk);
      checkOutput("strayIdle", busy, 0);
      checkOutput("strayNoIssue", validSeen, 0);
      fillRandom(3);
      clearRun();
      applyStimulus(3);
      repeat (4) @(negedge clk);
      applyStimulus(9);
      finishRun(200);
      checkRun(3);
      memLat = 1;

      $display("[TB] async reset during issue");
      fillRandom(2);
      stallIdx  = 0;
      stallLeft = 1000;
      clearRun();
      applyStimulus(2);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (iss_valid !== 1'b1 && n < 20);
      checkOutput("reachedIssue", iss_valid, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("rstDropValid", iss_valid, 0);
      checkOutput("rstDropBusy", busy, 0);
      checkOutput("rstDropReq", mem_req, 0);
      stallLeft = 0;
      stallIdx  = -1;
      @(negedge clk);
      rst = 1'b0;
      fillRandom(1);
      clearRun();
      applyStimulus(1);
      finishRun(50);
      checkRun(1);

      $display("[TB] randomized programs");
      randLat   = 1'b1;
      randReady = 1'b1;
      for (int r = 0; r < 6; r++) begin
         len = int'($urandom_range(1, 12));
         fillRandom(len);
         clearRun();
         applyStimulus(len);
         finishRun(len * 40 + 20);
         checkRun(len);
      end
      randLat   = 1'b0;
      randReady = 1'b0;

      $display("[TB] maximum program length");
      fillRandom(255);
      clearRun();
      applyStimulus(255);
      finishRun(255 * 8);
      checkRun(255);

`ifdef ALU_ISSUE_PARITY_EN
      $display("[TB] parity error aborts run");
      progMem[0]  = 19'h10503;
      progMem[1]  = 19'h20FF0;
      corruptAddr = 0;
      clearRun();
      applyStimulus(2);
      finishRun(20);
      checkOutput("parErrSet", par_err, 1);
      checkOutput("parNoIssue", validSeen, 0);
      checkOutput("parReqCount", reqQ.size(), 1);
      corruptAddr = -1;
      clearRun();
      applyStimulus(1);
      checkOutput("parErrCleared", par_err, 0);
      finishRun(20);
      checkRun(1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
